// File: rtl/hazard_ctrl_if.sv
// Hazard controller bundle: pipeline-side status in, stall/flush/MDU controls out.
// The pipeline drives through master; the controller uses slave.
interface hazard_ctrl_if #(parameter int CNT_W = 32);
   logic [4:0]       id_rs;
   logic [4:0]       id_rt;
   logic             id_use_rs;
   logic             id_use_rt;
   logic             id_use_hilo;
   logic             id_mdu_op;
   logic [4:0]       ex_dst;
   logic             ex_we;
   logic [4:0]       mem_dst;
   logic             mem_we;
   logic             mem_is_load;
   logic             ex_branch_taken;
   logic             dmem_wait;
   logic             pc_en;
   logic             ifid_en;
   logic             ifid_flush;
   logic             idex_flush;
   logic             pipe_freeze;
   logic             mdu_start;
   logic             mdu_busy;
   logic [CNT_W-1:0] stall_cycles;

   modport master (
      output id_rs, id_rt, id_use_rs, id_use_rt, id_use_hilo, id_mdu_op,
             ex_dst, ex_we, mem_dst, mem_we, mem_is_load, ex_branch_taken, dmem_wait,
      input  pc_en, ifid_en, ifid_flush, idex_flush, pipe_freeze, mdu_start,
             mdu_busy, stall_cycles
   );

   modport slave (
      input  id_rs, id_rt, id_use_rs, id_use_rt, id_use_hilo, id_mdu_op,
             ex_dst, ex_we, mem_dst, mem_we, mem_is_load, ex_branch_taken, dmem_wait,
      output pc_en, ifid_en, ifid_flush, idex_flush, pipe_freeze, mdu_start,
             mdu_busy, stall_cycles
   );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: IF/ID advance/stall/flush decisions, MDU busy
// tracking and a saturating stall-cycle counter.
//   state  | meaning
//   IDLE   | no mult/div in flight, HI/LO valid
//   BUSY   | mult/div running, cnt_q = remaining cycles - 1
module hazard_ctrl #(
   parameter int MDU_LAT = 4,
   parameter int CNT_W   = 32
) (
   input logic          clk,
   input logic          rst_n,
   hazard_ctrl_if.slave hif
);

   localparam int CW = (MDU_LAT > 1) ? $clog2(MDU_LAT) : 1;
   localparam logic [CW-1:0] CNT_LOAD = CW'(MDU_LAT - 1);

   typedef enum logic {S_IDLE, S_BUSY} mdu_state_e;

   mdu_state_e       state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;

   logic raw_ex, raw_ld, mdu_haz, stall_id, mdu_busy;
   logic pc_en, ifid_en, ifid_flush, idex_flush, pipe_freeze, mdu_start;

   assign mdu_busy = (state_q == S_BUSY);

   // $0 never matches because the producer side requires dst != 0
   always_comb begin
      raw_ex   = hif.ex_we && (hif.ex_dst != 5'd0) &&
                 ((hif.id_use_rs && (hif.id_rs == hif.ex_dst)) ||
                  (hif.id_use_rt && (hif.id_rt == hif.ex_dst)));
      raw_ld   = hif.mem_we && hif.mem_is_load && (hif.mem_dst != 5'd0) &&
                 ((hif.id_use_rs && (hif.id_rs == hif.mem_dst)) ||
                  (hif.id_use_rt && (hif.id_rt == hif.mem_dst)));
      mdu_haz  = mdu_busy && (hif.id_use_hilo || hif.id_mdu_op);
      stall_id = raw_ex || raw_ld || mdu_haz;
   end

   always_comb begin
      pc_en       = 1'b1;
      ifid_en     = 1'b1;
      ifid_flush  = 1'b0;
      idex_flush  = 1'b0;
      pipe_freeze = 1'b0;
      mdu_start   = 1'b0;
      if (hif.dmem_wait) begin
         pipe_freeze = 1'b1;
         pc_en       = 1'b0;
         ifid_en     = 1'b0;
      end else if (hif.ex_branch_taken) begin
         ifid_flush = 1'b1;
         idex_flush = 1'b1;
      end else if (stall_id) begin
         pc_en      = 1'b0;
         ifid_en    = 1'b0;
         idex_flush = 1'b1;
      end else begin
         mdu_start = hif.id_mdu_op;
      end
   end

   // A memory freeze holds the MDU countdown along with the rest of the pipe
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_IDLE: begin
            if (mdu_start) begin
               state_d = S_BUSY;
               cnt_d   = CNT_LOAD;
            end
         end
         S_BUSY: begin
            if (!hif.dmem_wait) begin
               if (cnt_q == '0) state_d = S_IDLE;
               else             cnt_d   = cnt_q - CW'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      stall_cycles_d = stall_cycles_q;
      if (stall_id && !hif.dmem_wait && !hif.ex_branch_taken &&
          (stall_cycles_q != '1))
         stall_cycles_d = stall_cycles_q + CNT_W'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= S_IDLE;
         cnt_q          <= '0;
         stall_cycles_q <= '0;
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         stall_cycles_q <= stall_cycles_d;
      end
   end

   assign hif.pc_en        = pc_en;
   assign hif.ifid_en      = ifid_en;
   assign hif.ifid_flush   = ifid_flush;
   assign hif.idex_flush   = idex_flush;
   assign hif.pipe_freeze  = pipe_freeze;
   assign hif.mdu_start    = mdu_start;
   assign hif.mdu_busy     = mdu_busy;
   assign hif.stall_cycles = stall_cycles_q;

endmodule
